regfile_writeback: RTL

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback_pkg.sv | 25 ++
 rtl/regfile_writeback_if.sv | 24 ++
 rtl/regfile_writeback_wb_stage.sv | 45 ++++
 rtl/regfile_writeback.sv | 87 ++++++++
 4 files changed

// File: rtl/regfile_writeback_pkg.sv
// Shared types and constants for the register-file writeback stage.
package regfile_writeback_pkg;

   localparam int WIDTH     = 16;
   localparam int REG_IDX_W = 3;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   localparam int PSW_C = 0;
   localparam int PSW_Z = 1;
   localparam int PSW_N = 2;
   localparam int PSW_V = 3;

   // Bank 1 read-only constants, index 0 at the least-significant slot.
   localparam logic [7:0][15:0] CONST_TABLE = {
      16'hFFFF, 16'd32, 16'd16, 16'd8, 16'd4, 16'd2, 16'd1, 16'd0
   };

   function automatic logic [3:0] flag_update(input logic [3:0] psw,
                                              input logic [3:0] mask,
                                              input logic [3:0] flags);
      return (psw & ~mask) | (flags & mask);
   endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Execute-to-writeback bus: result, control bits and pipeline stall/flush.
interface regfile_writeback_if #(
   parameter int WIDTH = 16
);
   logic             ex_valid;
   logic [2:0]       ex_dst;
   logic [WIDTH-1:0] ex_result;
   logic             ex_byte;
   logic             ex_wr_reg;
   logic [3:0]       ex_flag_mask;
   logic [3:0]       ex_flags;
   logic             stall;
   logic             flush;

   modport master (
      output ex_valid, ex_dst, ex_result, ex_byte, ex_wr_reg,
             ex_flag_mask, ex_flags, stall, flush
   );

   modport slave (
      input ex_valid, ex_dst, ex_result, ex_byte, ex_wr_reg,
            ex_flag_mask, ex_flags, stall, flush
   );
endinterface

// File: rtl/regfile_writeback_wb_stage.sv
// Single-entry WB capture register; flush beats stall, stall holds contents.
module wb_stage_reg #(
   parameter int WIDTH = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              stall,
   input  logic                              flush,
   input  logic                              load,
   input  regfile_writeback_pkg::reg_idx_t   d_dst,
   input  logic [WIDTH-1:0]                  d_data,
   input  logic                              d_wr_reg,
   input  logic [3:0]                        d_mask,
   input  logic [3:0]                        d_flags,
   output logic                              q_valid,
   output regfile_writeback_pkg::reg_idx_t   q_dst,
   output logic [WIDTH-1:0]                  q_data,
   output logic                              q_wr_reg,
   output logic [3:0]                        q_mask,
   output logic [3:0]                        q_flags
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q_valid  <= 1'b0;
         q_dst    <= '0;
         q_data   <= '0;
         q_wr_reg <= 1'b0;
         q_mask   <= '0;
         q_flags  <= '0;
      end else if (flush) begin
         q_valid <= 1'b0;
      end else if (!stall) begin
         q_valid <= load;
         if (load) begin
            q_dst    <= d_dst;
            q_data   <= d_data;
            q_wr_reg <= d_wr_reg;
            q_mask   <= d_mask;
            q_flags  <= d_flags;
         end
      end
   end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: captures execute results, merges byte writes, commits to
// R0-R7 and the PSW one edge later; bank 1 is a read-only constant table.
module regfile_writeback #(
   parameter int WIDTH    = regfile_writeback_pkg::WIDTH,
   parameter int NUM_REGS = 8
) (
   input  logic                                    clk,
   input  logic                                    rst,
   regfile_writeback_if.slave                      ex,
   output logic [1:0][NUM_REGS-1:0][WIDTH-1:0]     gprc_o,
   output logic [3:0]                              psw_o,
   output logic                                    pend_valid,
   output regfile_writeback_pkg::reg_idx_t         pend_dst,
   output logic [WIDTH-1:0]                        pend_data
);
   import regfile_writeback_pkg::*;

   logic [NUM_REGS-1:0][WIDTH-1:0] regs;

   logic             st_valid;
   reg_idx_t         st_dst;
   logic [WIDTH-1:0] st_data;
   logic             st_wr_reg;
   logic [3:0]       st_mask;
   logic [3:0]       st_flags;

   logic             fwd_hit;
   logic [WIDTH-1:0] merge_base;
   logic [WIDTH-1:0] cap_data;
   logic             commit;

   // The pending entry commits on the same edge a new result is captured, so
   // a byte op to the same register must merge against the pending value.
   always_comb begin
      fwd_hit    = st_valid && st_wr_reg && (st_dst == ex.ex_dst);
      merge_base = fwd_hit ? st_data : regs[ex.ex_dst];
      cap_data   = ex.ex_byte ? {merge_base[WIDTH-1:8], ex.ex_result[7:0]}
                              : ex.ex_result;
   end

   wb_stage_reg #(.WIDTH(WIDTH)) u_wb_stage (
      .clk      (clk),
      .rst      (rst),
      .stall    (ex.stall),
      .flush    (ex.flush),
      .load     (ex.ex_valid),
      .d_dst    (ex.ex_dst),
      .d_data   (cap_data),
      .d_wr_reg (ex.ex_wr_reg),
      .d_mask   (ex.ex_flag_mask),
      .d_flags  (ex.ex_flags),
      .q_valid  (st_valid),
      .q_dst    (st_dst),
      .q_data   (st_data),
      .q_wr_reg (st_wr_reg),
      .q_mask   (st_mask),
      .q_flags  (st_flags)
   );

   assign commit = st_valid && !ex.stall && !ex.flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         regs  <= '0;
         psw_o <= '0;
      end else if (commit) begin
         if (st_wr_reg) begin
            regs[st_dst] <= st_data;
         end
         psw_o <= flag_update(psw_o, st_mask, st_flags);
      end
   end

   always_comb begin
      gprc_o    = '0;
      gprc_o[0] = regs;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         gprc_o[1][i] = WIDTH'(CONST_TABLE[i[2:0]]);
      end
   end

   // Flags-only entries still occupy the stage but are not forwardable.
   assign pend_valid = st_valid && st_wr_reg;
   assign pend_dst   = st_dst;
   assign pend_data  = st_data;

endmodule
